// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered two-stage add/sub
// execute unit between NUM_REQ requesters. A tag pipe carries the requester
// id alongside the op so that each result is returned to the requester that
// issued it.
//
// Handshake: a request transfers when req_valid[i] && req_ready[i] are both
// high at a rising clock edge. req_ready is one-hot or zero and is a
// combinational function of req_valid, en and the round-robin pointer.
// A requester holds req_valid and its operands stable until it is accepted.
// rsp_valid is a one-cycle pulse with no backpressure.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op0,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ-1:0]        req_sel,
    output logic [DATA_W-1:0]         alu_op0,
    output logic [DATA_W-1:0]         alu_op1,
    output logic                      alu_sel,
    input  logic [DATA_W-1:0]         alu_result,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    // The last tag stage lines up with alu_result.
    localparam int LAST = ALU_LAT;

    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]           alu_op0_q, alu_op0_d;
    logic [DATA_W-1:0]           alu_op1_q, alu_op1_d;
    logic                        alu_sel_q, alu_sel_d;
    logic [LAST:0]               tag_vld_q, tag_vld_d;
    logic [LAST:0][ID_W-1:0]     tag_id_q, tag_id_d;

    logic                        grant_found;
    logic [ID_W-1:0]             grant_id;
    logic [ID_W:0]               scan_idx;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    // Grants are suppressed while reset is asserted so req_ready reads 0.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && reset_n && en && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // One-hot ready towards the granted requester.
    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next state: pointer advance, issue register load and tag pipe shift.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        alu_op0_d = alu_op0_q;
        alu_op1_d = alu_op1_q;
        alu_sel_d = alu_sel_q;
        if (grant_found) begin
            rr_ptr_d  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            alu_op0_d = req_op0[grant_id*DATA_W +: DATA_W];
            alu_op1_d = req_op1[grant_id*DATA_W +: DATA_W];
            alu_sel_d = req_sel[grant_id];
        end
        // The tag pipe never stalls; stage 0 is valid only on an accept.
        tag_vld_d = {tag_vld_q[LAST-1:0], grant_found};
        tag_id_d  = {tag_id_q[LAST-1:0], grant_id};
    end

    // State registers; reset discards every in-flight op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            alu_op0_q <= '0;
            alu_op1_q <= '0;
            alu_sel_q <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            alu_op0_q <= alu_op0_d;
            alu_op1_q <= alu_op1_d;
            alu_sel_q <= alu_sel_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Steer the result back to the requester recorded in the last tag stage.
    always_comb begin
        rsp_valid = '0;
        if (tag_vld_q[LAST]) begin
            rsp_valid[tag_id_q[LAST]] = 1'b1;
        end
    end

    assign rsp_data = alu_result;
    assign busy     = |tag_vld_q;
    assign alu_op0  = alu_op0_q;
    assign alu_op1  = alu_op1_q;
    assign alu_sel  = alu_sel_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int DEPTH = 4096;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_op0 = '0;
    logic [N*W-1:0]   req_op1 = '0;
    logic [N-1:0]     req_sel = '0;
    logic [W-1:0]     alu_op0;
    logic [W-1:0]     alu_op1;
    logic             alu_sel;
    logic [W-1:0]     alu_result;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             busy;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .ALU_LAT(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_sel    (req_sel),
        .alu_op0    (alu_op0),
        .alu_op1    (alu_op1),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    // Clock
    always #5 clock = ~clock;

    // Execute unit: input register then output register, no reset.
    logic [W-1:0] ex_a, ex_b, ex_res;
    logic         ex_s;
    always @(posedge clock) begin
        ex_a   <= alu_op0;
        ex_b   <= alu_op1;
        ex_s   <= alu_sel;
        ex_res <= ex_s ? (ex_a + ex_b) : (ex_a - ex_b);
    end
    assign alu_result = ex_res;

    // Requester state: a pending request stays put until accepted.
    bit           pend_v[N];
    logic [W-1:0] pend_a[N];
    logic [W-1:0] pend_b[N];
    bit           pend_s[N];

    // Reference model: round-robin pointer and a schedule of expected
    // responses indexed by the cycle they must appear in.
    int           rr;
    int           cyc;
    bit           exp_v[DEPTH];
    int           exp_id[DEPTH];
    logic [W-1:0] exp_d[DEPTH];

    int           n_vec;
    int           n_err;
    int           load;
    bit           en_cfg;
    bit           rst_cfg;
    logic [N-1:0] obs_ready;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        if (!pend_v[i]) begin
            pend_v[i] = 1'b1;
            pend_a[i] = a;
            pend_b[i] = b;
            pend_s[i] = s;
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the
    // model to account for the rising edge that follows.
    task automatic step();
        int           g;
        int           idx;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rv;
        bit           e_busy;
        @(negedge clock);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && ($urandom_range(0, 99) < load)) begin
                set_req(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend_v[i];
            req_op0[i*W +: W] = pend_a[i];
            req_op1[i*W +: W] = pend_b[i];
            req_sel[i]        = pend_s[i];
        end
        en      = en_cfg;
        reset_n = rst_cfg;
        #1;
        if (!reset_n) begin
            for (int c = cyc; c < cyc + 4; c++) exp_v[c] = 1'b0;
            rr = 0;
        end
        g = -1;
        if (reset_n && en) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && pend_v[idx]) g = idx;
            end
        end
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_rv = '0;
        if (exp_v[cyc]) e_rv[exp_id[cyc]] = 1'b1;
        e_busy = exp_v[cyc] | exp_v[cyc+1] | exp_v[cyc+2];
        obs_ready = req_ready;
        check_eq("req_ready", W'(req_ready), W'(e_ready));
        check_eq("rsp_valid", W'(rsp_valid), W'(e_rv));
        check_eq("busy", W'(busy), W'(e_busy));
        if (exp_v[cyc]) check_eq("rsp_data", rsp_data, exp_d[cyc]);
        if (g >= 0) begin
            exp_v[cyc+3]  = 1'b1;
            exp_id[cyc+3] = g;
            exp_d[cyc+3]  = pend_s[g] ? (pend_a[g] + pend_b[g]) : (pend_a[g] - pend_b[g]);
            rr            = (g + 1) % N;
            pend_v[g]     = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [N-1:0] rr_order[5];
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;
        rr_order[4] = 4'b0001;
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        rr = 0;
        load = 0;
        en_cfg = 1'b1;
        rst_cfg = 1'b0;
        for (int c = 0; c < DEPTH; c++) exp_v[c] = 1'b0;
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;

        // Reset for 3 cycles, then idle.
        steps(3);
        rst_cfg = 1'b1;
        steps(10);

        // Single add on requester 1: 5 + 7.
        set_req(1, 32'd5, 32'd7, 1'b1);
        steps(6);

        // Subtract wrap on requester 0: 3 - 5.
        set_req(0, 32'd3, 32'd5, 1'b0);
        steps(6);

        // Round-robin from a freshly reset pointer with everyone requesting.
        rst_cfg = 1'b0;
        steps(2);
        rst_cfg = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_req(i, W'(i), 32'd100, 1'b1);
            step();
            check_eq("rr_order", W'(obs_ready), W'(rr_order[k]));
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        steps(6);

        // en gating with traffic in flight and requests pending.
        load = 50;
        steps(6);
        en_cfg = 1'b0;
        steps(4);
        en_cfg = 1'b1;
        steps(6);
        load = 0;
        steps(10);

        // Reset while two ops are in flight.
        set_req(2, 32'd11, 32'd22, 1'b1);
        set_req(3, 32'd33, 32'd44, 1'b0);
        steps(2);
        rst_cfg = 1'b0;
        step();
        rst_cfg = 1'b1;
        set_req(0, 32'd1, 32'd2, 1'b1);
        set_req(1, 32'd3, 32'd4, 1'b1);
        step();
        check_eq("post_reset_grant", W'(obs_ready), 32'h1);
        steps(8);

        // Randomized traffic with occasional en drops.
        for (int blk = 0; blk < 15; blk++) begin
            load = $urandom_range(10, 100);
            for (int i = 0; i < 100; i++) begin
                en_cfg = ($urandom_range(0, 9) != 0);
                step();
            end
        end
        en_cfg = 1'b1;
        load = 0;
        steps(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
